// File: rtl/matmul_seq_ctrl.sv
// rtl/matmul_seq_ctrl.sv - matmul sequencer: operand fetch, multiplier handshake, biased writeback
// Optional feature: define MATMUL_CTRL_TIMEOUT_EN to enable the 8-bit COMPUTE watchdog.
module matmul_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32,
  localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
  localparam int IDX_W     = $clog2(MAX_DIM),
  localparam int NEL       = MAX_DIM * MAX_DIM
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic [2:0]                      n_dim_i,
  input  logic [2:0]                      k_dim_i,
  input  logic [2:0]                      m_dim_i,
  input  logic                            mode_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o,
  output logic                            rd_en_o,
  output logic [ADDR_WIDTH-1:0]           rd_addr_o,
  input  logic [BUS_WIDTH-1:0]            rd_data_i,
  output logic [NEL*DATA_WIDTH-1:0]       a_matrix_o,
  output logic [NEL*DATA_WIDTH-1:0]       b_matrix_o,
  output logic                            mm_start_o,
  input  logic                            mm_finish_i,
  input  logic [NEL*BUS_WIDTH-1:0]        c_matrix_i,
  input  logic [NEL-1:0]                  flags_i,
  output logic                            wr_en_o,
  output logic [ADDR_WIDTH-1:0]           wr_addr_o,
  output logic [BUS_WIDTH-1:0]            wr_data_o,
  output logic [BUS_WIDTH-1:0]            flags_o
);

  localparam int         EL_W     = 2 * IDX_W;
  localparam logic [4:0] OP_A     = 5'b00100;
  localparam logic [4:0] OP_B     = 5'b01000;
  localparam logic [4:0] OP_C     = 5'b10000;
  localparam logic [2:0] MAX_DIM3 = 3'(MAX_DIM);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_LOAD_C, S_DRAIN, S_COMPUTE, S_WRITE, S_DONE
  } state_t;

  typedef enum logic [1:0] {CAP_NONE, CAP_A, CAP_B, CAP_C} cap_t;

  state_t              state_q, state_d;
  logic [2:0]          ri_q, ri_d, cj_q, cj_d;
  logic [2:0]          n_q, k_q, m_q;
  logic                mode_q;
  logic                accept, reject, timeout;
  cap_t                cap_op, pend_op_q;
  logic [EL_W-1:0]     cap_idx, pend_idx_q;
  logic                pend_q;
  logic                err_q;
  logic [BUS_WIDTH-1:0] flags_q;
  logic [BUS_WIDTH-1:0] a_img [MAX_DIM];
  logic [BUS_WIDTH-1:0] b_img [MAX_DIM];
  logic [BUS_WIDTH-1:0] bias  [NEL];
  logic                dims_bad;
  logic                last_i, last_j;
  logic [EL_W-1:0]     row_el, cur_el;

`ifdef MATMUL_CTRL_TIMEOUT_EN
  logic [7:0]          wd_q;
`endif

  // Operand address: index field above the 5-bit operand code, all else zero.
  function automatic logic [ADDR_WIDTH-1:0] make_addr(input logic [4:0] op, input logic [EL_W-1:0] idx);
    make_addr = ADDR_WIDTH'({idx, op});
  endfunction

  // MAX_DIM is a power of two, so i*MAX_DIM+j is a plain concatenation.
  assign cur_el   = {ri_q[IDX_W-1:0], cj_q[IDX_W-1:0]};
  assign row_el   = EL_W'(ri_q[IDX_W-1:0]);
  assign last_i   = (ri_q == n_q - 3'd1);
  assign last_j   = (cj_q == m_q - 3'd1);
  assign dims_bad = (n_dim_i == 3'd0) || (n_dim_i > MAX_DIM3) ||
                    (k_dim_i == 3'd0) || (k_dim_i > MAX_DIM3) ||
                    (m_dim_i == 3'd0) || (m_dim_i > MAX_DIM3);

  assign busy_o  = (state_q != S_IDLE);
  assign err_o   = err_q;
  assign flags_o = flags_q;

  for (genvar r = 0; r < MAX_DIM; r++) begin : g_rows
    assign a_matrix_o[r*BUS_WIDTH +: BUS_WIDTH] = a_img[r];
    assign b_matrix_o[r*BUS_WIDTH +: BUS_WIDTH] = b_img[r];
  end

  // State and loop-index registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ri_q    <= '0;
      cj_q    <= '0;
    end else begin
      state_q <= state_d;
      ri_q    <= ri_d;
      cj_q    <= cj_d;
    end
  end

  // Next state, loop stepping and all per-cycle strobes/addresses.
  always_comb begin
    state_d    = state_q;
    ri_d       = ri_q;
    cj_d       = cj_q;
    accept     = 1'b0;
    reject     = 1'b0;
    timeout    = 1'b0;
    rd_en_o    = 1'b0;
    rd_addr_o  = '0;
    cap_op     = CAP_NONE;
    cap_idx    = '0;
    wr_en_o    = 1'b0;
    wr_addr_o  = '0;
    wr_data_o  = '0;
    mm_start_o = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (dims_bad) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = S_LOAD_A;
            ri_d    = '0;
            cj_d    = '0;
          end
        end
      end
      S_LOAD_A: begin
        rd_en_o   = 1'b1;
        rd_addr_o = make_addr(OP_A, row_el);
        cap_op    = CAP_A;
        cap_idx   = row_el;
        if (last_i) begin
          ri_d    = '0;
          state_d = S_LOAD_B;
        end else begin
          ri_d = ri_q + 3'd1;
        end
      end
      S_LOAD_B: begin
        rd_en_o   = 1'b1;
        rd_addr_o = make_addr(OP_B, row_el);
        cap_op    = CAP_B;
        cap_idx   = row_el;
        if (ri_q == k_q - 3'd1) begin
          ri_d    = '0;
          state_d = mode_q ? S_LOAD_C : S_DRAIN;
        end else begin
          ri_d = ri_q + 3'd1;
        end
      end
      S_LOAD_C: begin
        rd_en_o   = 1'b1;
        rd_addr_o = make_addr(OP_C, cur_el);
        cap_op    = CAP_C;
        cap_idx   = cur_el;
        if (last_j) begin
          cj_d = '0;
          if (last_i) begin
            ri_d    = '0;
            state_d = S_DRAIN;
          end else begin
            ri_d = ri_q + 3'd1;
          end
        end else begin
          cj_d = cj_q + 3'd1;
        end
      end
      S_DRAIN: begin
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        mm_start_o = 1'b1;
        if (mm_finish_i) begin
          state_d = S_WRITE;
          ri_d    = '0;
          cj_d    = '0;
        end
`ifdef MATMUL_CTRL_TIMEOUT_EN
        else if (wd_q == 8'd254) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      S_WRITE: begin
        wr_en_o   = 1'b1;
        wr_addr_o = make_addr(OP_C, cur_el);
        wr_data_o = c_matrix_i[int'(cur_el)*BUS_WIDTH +: BUS_WIDTH] + bias[cur_el];
        if (last_j) begin
          cj_d = '0;
          if (last_i) begin
            ri_d    = '0;
            state_d = S_DONE;
          end else begin
            ri_d = ri_q + 3'd1;
          end
        end else begin
          cj_d = cj_q + 3'd1;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Job latches, operand images filled one cycle after each read, flag capture and error pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_q        <= '0;
      k_q        <= '0;
      m_q        <= '0;
      mode_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_op_q  <= CAP_NONE;
      pend_idx_q <= '0;
      err_q      <= 1'b0;
      flags_q    <= '0;
      for (int r = 0; r < MAX_DIM; r++) begin
        a_img[r] <= '0;
        b_img[r] <= '0;
      end
      for (int e = 0; e < NEL; e++) bias[e] <= '0;
    end else begin
      err_q      <= reject | timeout;
      pend_q     <= rd_en_o;
      pend_op_q  <= cap_op;
      pend_idx_q <= cap_idx;
      if (pend_q) begin
        case (pend_op_q)
          CAP_A:   a_img[pend_idx_q[IDX_W-1:0]] <= rd_data_i;
          CAP_B:   b_img[pend_idx_q[IDX_W-1:0]] <= rd_data_i;
          CAP_C:   bias[pend_idx_q]             <= rd_data_i;
          default: ;
        endcase
      end
      if (accept) begin
        n_q     <= n_dim_i;
        k_q     <= k_dim_i;
        m_q     <= m_dim_i;
        mode_q  <= mode_i;
        flags_q <= '0;
        for (int r = 0; r < MAX_DIM; r++) begin
          a_img[r] <= '0;
          b_img[r] <= '0;
        end
        for (int e = 0; e < NEL; e++) bias[e] <= '0;
      end
      if (state_q == S_COMPUTE && mm_finish_i) flags_q <= BUS_WIDTH'(flags_i);
    end
  end

`ifdef MATMUL_CTRL_TIMEOUT_EN
  // Watchdog: counts consecutive COMPUTE cycles without a finish.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q <= '0;
    end else if (state_q == S_COMPUTE && !mm_finish_i) begin
      wd_q <= wd_q + 8'd1;
    end else begin
      wd_q <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb/tb_matmul_seq_ctrl.sv - self-checking bench for matmul_seq_ctrl against a job-level reference model
module tb_matmul_seq_ctrl;

  localparam int MD  = 2;
  localparam int NEL = 4;
  localparam logic [4:0] OP_A = 5'b00100;
  localparam logic [4:0] OP_B = 5'b01000;
  localparam logic [4:0] OP_C = 5'b10000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  n_dim_i, k_dim_i, m_dim_i;
  logic        mode_i;
  logic        busy_o, done_o, err_o;
  logic        rd_en_o;
  logic [31:0] rd_addr_o;
  logic [15:0] rd_data_i = 16'h0;
  logic [31:0] a_matrix_o, b_matrix_o;
  logic        mm_start_o;
  logic        mm_finish_i;
  logic [63:0] c_matrix_i;
  logic [3:0]  flags_i;
  logic        wr_en_o;
  logic [31:0] wr_addr_o;
  logic [15:0] wr_data_o;
  logic [15:0] flags_o;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] spm [256];

  logic [31:0] obs_rd [$];
  logic [47:0] obs_wr [$];
  int done_cnt = 0, err_cnt = 0, busy_cnt = 0, start_cnt = 0;

  matmul_seq_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .n_dim_i(n_dim_i), .k_dim_i(k_dim_i), .m_dim_i(m_dim_i), .mode_i(mode_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .a_matrix_o(a_matrix_o), .b_matrix_o(b_matrix_o),
    .mm_start_o(mm_start_o), .mm_finish_i(mm_finish_i),
    .c_matrix_i(c_matrix_i), .flags_i(flags_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .flags_o(flags_o)
  );

  always #5 clk_i = ~clk_i;

  // Scratchpad: one-cycle read latency.
  always @(posedge clk_i) begin
    if (rd_en_o) rd_data_i <= spm[rd_addr_o[7:0]];
  end

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (rd_en_o)    obs_rd.push_back(rd_addr_o);
    if (wr_en_o)    obs_wr.push_back({wr_addr_o, wr_data_o});
    if (done_o)     done_cnt++;
    if (err_o)      err_cnt++;
    if (busy_o)     busy_cnt++;
    if (mm_start_o) start_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] op_addr(input logic [4:0] op, input int idx);
    op_addr = {27'(idx), op};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  64'(busy_o), 64'd0);
    check({tag, "_done"},  64'(done_o), 64'd0);
    check({tag, "_err"},   64'(err_o), 64'd0);
    check({tag, "_rden"},  64'(rd_en_o), 64'd0);
    check({tag, "_wren"},  64'(wr_en_o), 64'd0);
    check({tag, "_mmst"},  64'(mm_start_o), 64'd0);
    check({tag, "_rdad"},  64'(rd_addr_o), 64'd0);
    check({tag, "_wrad"},  64'(wr_addr_o), 64'd0);
    check({tag, "_wrdt"},  64'(wr_data_o), 64'd0);
    check({tag, "_flags"}, 64'(flags_o), 64'd0);
    check({tag, "_aimg"},  64'(a_matrix_o), 64'd0);
    check({tag, "_bimg"},  64'(b_matrix_o), 64'd0);
  endtask

  task automatic fill_random;
    for (int a = 0; a < 256; a++) spm[a] = 16'($urandom);
    c_matrix_i = {$urandom, $urandom};
    flags_i    = 4'($urandom_range(1, 15));
  endtask

  task automatic run_job(input int n, input int k, input int m, input bit mode,
                         input int fin_delay, input bit poke_start);
    logic [31:0] exp_rd [$];
    logic [47:0] exp_wr [$];
    logic [31:0] exp_a, exp_b, cap_a, cap_b, ad;
    logic [15:0] cap_f, bias, wd;
    int rb, wb, db, eb, bb, sb, cyc, comp, e, exp_busy;
    bit seen, poked;

    exp_a = '0;
    exp_b = '0;
    for (int r = 0; r < n; r++) begin
      ad = op_addr(OP_A, r);
      exp_rd.push_back(ad);
      exp_a[r*16 +: 16] = spm[ad[7:0]];
    end
    for (int r = 0; r < k; r++) begin
      ad = op_addr(OP_B, r);
      exp_rd.push_back(ad);
      exp_b[r*16 +: 16] = spm[ad[7:0]];
    end
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < m; j++) begin
        e  = i * MD + j;
        ad = op_addr(OP_C, e);
        if (mode) exp_rd.push_back(ad);
        bias = mode ? spm[ad[7:0]] : 16'h0;
        wd   = c_matrix_i[e*16 +: 16] + bias;
        exp_wr.push_back({ad, wd});
      end
    end
    exp_busy = n + k + (mode ? n * m : 0) + 1 + (fin_delay + 1) + n * m + 1;

    @(posedge clk_i); #1;
    rb = obs_rd.size(); wb = obs_wr.size();
    db = done_cnt; eb = err_cnt; bb = busy_cnt; sb = start_cnt;

    @(negedge clk_i);
    start_i = 1'b1; n_dim_i = 3'(n); k_dim_i = 3'(k); m_dim_i = 3'(m); mode_i = mode;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 0; comp = 0; seen = 0; poked = 0;
    cap_a = '0; cap_b = '0; cap_f = 16'hDEAD;
    while (!seen && cyc < 3000) begin
      if (mm_start_o) begin
        if (comp == 0) begin
          cap_a = a_matrix_o; cap_b = b_matrix_o; cap_f = flags_o;
        end
        if (comp == fin_delay) mm_finish_i = 1'b1;
        comp++;
      end else begin
        mm_finish_i = 1'b0;
      end
      if (poke_start && wr_en_o && !poked) begin
        start_i = 1'b1;
        poked   = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      if (done_o) seen = 1'b1;
      if (!seen) begin
        @(negedge clk_i);
        cyc++;
      end
    end
    mm_finish_i = 1'b0;
    start_i     = 1'b0;
    @(posedge clk_i); #1;

    check("done_seen", 64'(seen), 64'd1);
    check("rd_count", 64'(obs_rd.size() - rb), 64'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size(); i++)
      if (rb + i < obs_rd.size()) check("rd_addr", 64'(obs_rd[rb + i]), 64'(exp_rd[i]));
    check("wr_count", 64'(obs_wr.size() - wb), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++)
      if (wb + i < obs_wr.size()) check("wr_addr_data", 64'(obs_wr[wb + i]), 64'(exp_wr[i]));
    check("a_image", 64'(cap_a), 64'(exp_a));
    check("b_image", 64'(cap_b), 64'(exp_b));
    check("flags_cleared", 64'(cap_f), 64'd0);
    check("flags_o", 64'(flags_o), 64'(flags_i));
    check("busy_cycles", 64'(busy_cnt - bb), 64'(exp_busy));
    check("mm_start_cycles", 64'(start_cnt - sb), 64'(fin_delay + 1));
    check("done_pulses", 64'(done_cnt - db), 64'd1);
    check("err_pulses", 64'(err_cnt - eb), 64'd0);

    if (poke_start) begin
      rb = obs_rd.size(); bb = busy_cnt;
      repeat (5) @(negedge clk_i);
      @(posedge clk_i); #1;
      check("poke_no_busy", 64'(busy_cnt - bb), 64'd0);
      check("poke_no_reads", 64'(obs_rd.size() - rb), 64'd0);
    end
  endtask

  task automatic reject_job(input int n, input int k, input int m);
    int rb, wb, eb, bb;
    @(posedge clk_i); #1;
    rb = obs_rd.size(); wb = obs_wr.size(); eb = err_cnt; bb = busy_cnt;
    @(negedge clk_i);
    start_i = 1'b1; n_dim_i = 3'(n); k_dim_i = 3'(k); m_dim_i = 3'(m); mode_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    @(posedge clk_i); #1;
    check("rej_err_pulses", 64'(err_cnt - eb), 64'd1);
    check("rej_reads", 64'(obs_rd.size() - rb), 64'd0);
    check("rej_writes", 64'(obs_wr.size() - wb), 64'd0);
    check("rej_busy", 64'(busy_cnt - bb), 64'd0);
  endtask

  task automatic reset_mid_write;
    int wb, db, cyc, wseen;
    bit hit;
    fill_random();
    @(posedge clk_i); #1;
    wb = obs_wr.size(); db = done_cnt;
    @(negedge clk_i);
    start_i = 1'b1; n_dim_i = 3'd2; k_dim_i = 3'd2; m_dim_i = 3'd2; mode_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 0; wseen = 0; hit = 0;
    while (!hit && cyc < 200) begin
      mm_finish_i = mm_start_o;
      if (wr_en_o) begin
        wseen++;
        if (wseen == 2) begin
          rst_i = 1'b1;
          hit   = 1'b1;
        end
      end
      if (!hit) begin
        @(negedge clk_i);
        cyc++;
      end
    end
    mm_finish_i = 1'b0;
    check("rst_reached_write2", 64'(hit), 64'd1);
    @(posedge clk_i); #1;
    check_idle("rstmid");
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    @(posedge clk_i); #1;
    check("rstmid_writes", 64'(obs_wr.size() - wb), 64'd2);
    check("rstmid_no_done", 64'(done_cnt - db), 64'd0);
  endtask

`ifdef MATMUL_CTRL_TIMEOUT_EN
  task automatic timeout_job;
    int wb, db, eb, cyc, comp;
    bit back;
    fill_random();
    @(posedge clk_i); #1;
    wb = obs_wr.size(); db = done_cnt; eb = err_cnt;
    @(negedge clk_i);
    start_i = 1'b1; n_dim_i = 3'd1; k_dim_i = 3'd1; m_dim_i = 3'd1; mode_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    mm_finish_i = 1'b0;
    cyc = 0; comp = 0; back = 0;
    while (!back && cyc < 600) begin
      if (mm_start_o) comp++;
      if (!busy_o) back = 1'b1;
      if (!back) begin
        @(negedge clk_i);
        cyc++;
      end
    end
    @(posedge clk_i); #1;
    check("to_back_idle", 64'(back), 64'd1);
    check("to_compute_cycles", 64'(comp), 64'd255);
    check("to_err_pulses", 64'(err_cnt - eb), 64'd1);
    check("to_writes", 64'(obs_wr.size() - wb), 64'd0);
    check("to_no_done", 64'(done_cnt - db), 64'd0);
  endtask
`endif

  initial begin
    rst_i = 1'b1; start_i = 1'b0; n_dim_i = '0; k_dim_i = '0; m_dim_i = '0; mode_i = 1'b0;
    mm_finish_i = 1'b0; c_matrix_i = '0; flags_i = '0;
    for (int a = 0; a < 256; a++) spm[a] = 16'h0;
    repeat (3) @(posedge clk_i);
    #1;
    check_idle("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    // 2x2x2, no bias, known operand rows
    fill_random();
    spm[8'h04] = 16'h0201; spm[8'h24] = 16'h0403;
    spm[8'h08] = 16'h0605; spm[8'h28] = 16'h0807;
    run_job(2, 2, 2, 1'b0, 3, 1'b0);

    // bias mode with wrap on element 0
    fill_random();
    spm[8'h10] = 16'd1; spm[8'h30] = 16'd2; spm[8'h50] = 16'd3; spm[8'h70] = 16'd4;
    c_matrix_i = {16'd30, 16'd20, 16'd10, 16'hFFFF};
    run_job(2, 2, 2, 1'b1, 0, 1'b0);
    if (obs_wr.size() >= 4) check("bias_wrap", 64'(obs_wr[obs_wr.size() - 4][15:0]), 64'h0000);

    // narrow shape, unused A row stays zero
    fill_random();
    run_job(1, 2, 1, 1'b0, 1, 1'b0);

    // rejected starts
    reject_job(2, 2, 3);
    reject_job(2, 2, 0);
    reject_job(0, 1, 1);
    reject_job(1, 3, 2);

    // start during WRITE is ignored
    fill_random();
    run_job(2, 1, 2, 1'b1, 2, 1'b1);

    // reset in the second WRITE cycle, then a clean job
    reset_mid_write();
    fill_random();
    run_job(2, 2, 2, 1'b1, 1, 1'b0);

    // randomized jobs
    for (int t = 0; t < 25; t++) begin
      fill_random();
      run_job($urandom_range(1, MD), $urandom_range(1, MD), $urandom_range(1, MD),
              1'($urandom_range(0, 1)), $urandom_range(0, 6), 1'b0);
    end

`ifdef MATMUL_CTRL_TIMEOUT_EN
    timeout_job();
    fill_random();
    run_job(1, 1, 2, 1'b1, 0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
